// File: rtl/operand_loader_pkg.sv
// Shared types and sizing helpers for the framed serial operand loader.
package operand_loader_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Bit counter width; never below one bit so the counter always exists.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Serial load side and parallel operand handshake of the operand loader.
interface operand_loader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             bit_valid;
    logic             ser_a;
    logic             ser_b;
    logic             op_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output start, bit_valid, ser_a, ser_b, op_ready,
        input  op_a, op_b, op_valid, busy, overrun
    );

    modport slave (
        input  start, bit_valid, ser_a, ser_b, op_ready,
        output op_a, op_b, op_valid, busy, overrun
    );
endinterface

// File: rtl/operand_loader_sipo_shift.sv
// Serial-in/parallel-out register, MSB first, with shift enable and clear.
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (clr) begin
            sh_d = '0;
        end else if (shift_en) begin
            sh_d = {sh_q[WIDTH-2:0], ser_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign par_out = sh_q;

endmodule

// File: rtl/operand_loader.sv
// Frames two MSB-first serial operands and presents each completed pair on a
// valid/ready handshake backed by one-deep holding registers.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    operand_loader_if.slave       lb
);

    localparam int CW = cnt_w(WIDTH);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("operand_loader: WIDTH out of range");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic             overrun_q, overrun_d;

    logic             sh_clr;
    logic             sh_en;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             xfer;
    logic             hold_free;
    logic             last_bit;

    sipo_shift #(.WIDTH(WIDTH)) u_sh_a (
        .clk      (clk),
        .reset    (reset),
        .clr      (sh_clr),
        .shift_en (sh_en),
        .ser_in   (lb.ser_a),
        .par_out  (sh_a)
    );

    sipo_shift #(.WIDTH(WIDTH)) u_sh_b (
        .clk      (clk),
        .reset    (reset),
        .clr      (sh_clr),
        .shift_en (sh_en),
        .ser_in   (lb.ser_b),
        .par_out  (sh_b)
    );

    assign xfer      = op_valid_q & lb.op_ready;
    assign hold_free = ~op_valid_q | xfer;
    assign last_bit  = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        overrun_d  = overrun_q;
        sh_clr     = 1'b0;
        sh_en      = 1'b0;

        if (enable) begin
            // A transfer empties the holding regs unless a branch below refills them.
            if (xfer) begin
                op_valid_d = 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (lb.start) begin
                        state_d = SHIFT;
                        count_d = '0;
                        sh_clr  = 1'b1;
                    end
                end

                SHIFT: begin
                    if (lb.start) begin
                        count_d = '0;
                        sh_clr  = 1'b1;
                    end else if (lb.bit_valid) begin
                        sh_en = 1'b1;
                        if (last_bit) begin
                            count_d = '0;
                            if (hold_free) begin
                                op_a_d     = {sh_a[WIDTH-2:0], lb.ser_a};
                                op_b_d     = {sh_b[WIDTH-2:0], lb.ser_b};
                                op_valid_d = 1'b1;
                                state_d    = IDLE;
                            end else begin
                                state_d = HOLD;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (xfer) begin
                        op_a_d     = sh_a;
                        op_b_d     = sh_b;
                        op_valid_d = 1'b1;
                        state_d    = IDLE;
                    end
                    if (lb.bit_valid) begin
                        overrun_d = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign lb.op_a     = op_a_q;
    assign lb.op_b     = op_b_q;
    assign lb.op_valid = op_valid_q;
    assign lb.busy     = (state_q != IDLE);
    assign lb.overrun  = overrun_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader at WIDTH=8 with hand-computed expectations.
module tb_operand_loader;

    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    logic enable;
    int   checks;
    int   failures;

    operand_loader_if #(.WIDTH(WIDTH)) bus ();

    operand_loader #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .lb     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
        bus.start     = 1'b1;
        bus.bit_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bus.bit_valid = 1'b1;
            bus.ser_a     = a[i];
            bus.ser_b     = b[i];
            tick();
        end
        bus.bit_valid = 1'b0;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic vld, input logic bsy);
        check({tag, "_op_a"}, 32'(bus.op_a), 32'(a));
        check({tag, "_op_b"}, 32'(bus.op_b), 32'(b));
        check({tag, "_op_valid"}, 32'(bus.op_valid), 32'(vld));
        check({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        enable        = 1'b1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.ser_a     = 1'b0;
        bus.ser_b     = 1'b0;
        bus.op_ready  = 1'b1;

        // reset then idle
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check_out("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);

        // bit_valid alone in IDLE is ignored
        bus.bit_valid = 1'b1;
        bus.ser_a     = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        check("idle_bv_busy", 32'(bus.busy), 32'd0);
        check("idle_bv_overrun", 32'(bus.overrun), 32'd0);

        // basic frame with consumer ready
        send_frame(8'hA5, 8'h3C);
        check_out("basic", 8'hA5, 8'h3C, 1'b1, 1'b0);
        tick();
        check("basic_consumed", 32'(bus.op_valid), 32'd0);

        // back-pressure: second frame parks in HOLD
        bus.op_ready = 1'b0;
        send_frame(8'hA5, 8'h3C);
        check_out("bp_first", 8'hA5, 8'h3C, 1'b1, 1'b0);
        send_frame(8'h5A, 8'hC3);
        check_out("bp_hold", 8'hA5, 8'h3C, 1'b1, 1'b1);

        // bit in HOLD is dropped and flagged; start in HOLD is ignored
        bus.bit_valid = 1'b1;
        bus.ser_a     = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        bus.ser_a     = 1'b0;
        bus.start     = 1'b0;
        check("hold_overrun", 32'(bus.overrun), 32'd1);
        check("hold_busy", 32'(bus.busy), 32'd1);

        bus.op_ready = 1'b1;
        tick();
        check_out("hold_release", 8'h5A, 8'hC3, 1'b1, 1'b0);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);
        tick();
        check("release_consumed", 32'(bus.op_valid), 32'd0);

        // restart mid-frame discards partial bits
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1'b1;
            bus.ser_a     = (i != 1);
            bus.ser_b     = 1'b1;
            tick();
        end
        send_frame(8'hFF, 8'h01);
        check_out("restart", 8'hFF, 8'h01, 1'b1, 1'b0);
        tick();

        // enable low freezes a frame in progress
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 7; i >= 4; i--) begin
            bus.bit_valid = 1'b1;
            bus.ser_a     = 8'hA5 >> i;
            bus.ser_b     = 8'h3C >> i;
            tick();
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bit_valid = i[0];
            bus.ser_a     = 1'b1;
            bus.ser_b     = 1'b1;
            tick();
        end
        check("freeze_busy", 32'(bus.busy), 32'd1);
        check("freeze_valid", 32'(bus.op_valid), 32'd0);
        enable = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bus.bit_valid = 1'b1;
            bus.ser_a     = 8'hA5 >> i;
            bus.ser_b     = 8'h3C >> i;
            tick();
        end
        bus.bit_valid = 1'b0;
        check_out("resume", 8'hA5, 8'h3C, 1'b1, 1'b0);

        // op_ready is ignored while disabled
        enable = 1'b0;
        tick();
        check("dis_ready_ignored", 32'(bus.op_valid), 32'd1);
        enable = 1'b1;
        tick();
        check("en_consumed", 32'(bus.op_valid), 32'd0);

        // reset mid-frame
        send_frame(8'h12, 8'h34);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1'b1;
            bus.ser_a     = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.bit_valid = 1'b0;
        check_out("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check("mid_reset_overrun", 32'(bus.overrun), 32'd0);
        tick();

        // fresh frame after reset works from a clean counter
        send_frame(8'h81, 8'h7E);
        check_out("post_reset", 8'h81, 8'h7E, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
